motion_mag_ctrl: RTL and testbench
==================================

MOTION_MAG_CTRL -- requirements
Module: motion_mag_ctrl

Interface
REQ-001 Parameter: ODO_W, 16, odometer accumulator width in bits (legal range 12..32).
REQ-002 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: in_valid  in  1  motion packet present.
REQ-005 Port: in_ready  out  1  block can accept a packet.
REQ-006 Port: in_x  in  9  X movement, two's complement (-256..255).
REQ-007 Port: in_y  in  9  Y movement, two's complement (-256..255).
REQ-008 Port: in_xovf  in  1  PS/2 X overflow flag.
REQ-009 Port: in_yovf  in  1  PS/2 Y overflow flag.
REQ-010 Port: out_valid  out  1  magnitude result available.
REQ-011 Port: out_ready  in  1  consumer takes the result.
REQ-012 Port: out_z  out  9  floor(sqrt(x^2+y^2)), unsigned.
REQ-013 Port: out_sat  out  1  result forced by an overflow flag.
REQ-014 Port: odo  out  ODO_W  accumulated distance.
REQ-015 Port: odo_clr  in  1  clear odometer.

Function
REQ-016 The FSM SHALL have states IDLE, ABS, SUM, ROOT, OUT; in_ready = 1 only in IDLE.
REQ-017 On a rising edge with in_valid && in_ready, the block SHALL latch in_x, in_y, in_xovf, in_yovf and go IDLE->ABS.
REQ-018 ABS SHALL form 9-bit unsigned magnitudes (|-256| = 256, no 8-bit truncation), then go ->SUM.
REQ-019 SUM SHALL register the 18-bit sum |x|^2+|y|^2 (max 131072, no overflow), then go ->ROOT with bit index 8.
REQ-020 ROOT SHALL resolve one result bit per cycle, MSB (bit 8) first, by trial-set and compare: keep the bit iff trial^2 <= sum; after bit 0 it SHALL go ->OUT.
REQ-021 Latency SHALL be fixed: out_valid rises exactly 11 rising edges after the accepting edge, independent of operand values and flags.
REQ-022 If either latched ovf flag is 1, out_z SHALL be 9'h1FF and out_sat = 1; the FSM still passes through all states with unchanged latency.
REQ-023 In OUT, out_valid = 1 and out_z/out_sat SHALL hold stable until out_valid && out_ready, then go ->IDLE; one packet is in flight at most.
REQ-024 in_ready SHALL be 0 in OUT; the consumer handshake edge and a new accept never coincide (a new accept is possible from the next cycle at the earliest).
REQ-025 out_z/out_sat SHALL keep the last result value outside OUT; only out_valid qualifies them.

Reset
REQ-026 When rst = 1 at a rising edge: FSM->IDLE, out_valid = 0, out_z = 0, out_sat = 0, odo = 0, and all datapath registers = 0.
REQ-027 A reset mid-operation (any state) SHALL abort the packet with no output, and in_ready SHALL be 1 in the cycle after the reset is released.

Configuration
REQ-028 Macro MOTION_MAG_ODO_EN defined: odo adds out_z on each output handshake and saturates at all-ones; odo_clr = 1 zeroes it; if odo_clr coincides with a handshake, the clear wins.
REQ-029 Macro MOTION_MAG_ODO_EN undefined: odo is driven constant 0 and odo_clr is ignored; the ports remain present.

Structure
REQ-030 Package ps2_mouse_pkg SHALL hold the FSM state typedef, MOVE_W = 9, SUMSQ_W = 18, ROOT_STEPS = 9 and the saturation constant 9'h1FF.
REQ-031 The ROOT iteration SHALL live in one sub-module, mag_isqrt_step (combinational trial-bit compare, no state); the FSM and registers stay in motion_mag_ctrl.

Verification
REQ-032 Handshake (x=3, y=-4, out_ready=1): out_z = 5, out_sat = 0, out_valid on the 11th edge after accept.
REQ-033 Extremes: (-256, -256) -> out_z = 362; (0, 0) -> 0; (255, 0) -> 255.
REQ-034 Overflow: in_xovf = 1, (x=10, y=10) -> out_z = 511, out_sat = 1, same latency.
REQ-035 Backpressure: out_ready held 0 for 20 cycles -> out_valid and out_z stable, in_ready = 0 throughout, and a pending in_valid is not accepted.
REQ-036 Reset in ROOT: pulse rst -> no out_valid; the next packet (6, 8) yields 10.
REQ-037 With MOTION_MAG_ODO_EN: packets 5, 10, 13 -> odo = 28; odo_clr together with a handshake -> odo = 0; preload near the ceiling -> odo saturates at 0xFFFF (ODO_W = 16).

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 motion magnitude block.
// Used by motion_mag_ctrl and mag_isqrt_step.
package ps2_mouse_pkg;

    localparam int MOVE_W     = 9;
    localparam int SUMSQ_W    = 18;
    localparam int ROOT_STEPS = 9;
    localparam int BIT_IDX_W  = 4;

    localparam logic [MOVE_W-1:0] SAT_Z = 9'h1FF;

    typedef enum logic [2:0] {
        IDLE,
        ABS,
        SUM,
        ROOT,
        OUT
    } mag_state_t;

    // Magnitude as an unsigned 9-bit value so that -256 maps to 256.
    function automatic logic [MOVE_W-1:0] abs_move(input logic [MOVE_W-1:0] v);
        return v[MOVE_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mag_isqrt_step.sv
// One restoring integer square-root step: trial-set a bit, keep it if trial^2 <= sum.
// Purely combinational; the iteration state lives in motion_mag_ctrl.
module mag_isqrt_step
    import ps2_mouse_pkg::*;
(
    input  logic [SUMSQ_W-1:0]   sum,
    input  logic [MOVE_W-1:0]    root,
    input  logic [BIT_IDX_W-1:0] bit_idx,
    output logic [MOVE_W-1:0]    root_next
);

    logic [MOVE_W-1:0]  trial;
    logic [SUMSQ_W-1:0] trial_wide;
    logic [SUMSQ_W-1:0] trial_sq;

    // 511^2 still fits in 18 bits, so the square never wraps.
    always_comb begin
        trial      = root | (MOVE_W'(1) << bit_idx);
        trial_wide = SUMSQ_W'(trial);
        trial_sq   = trial_wide * trial_wide;
        root_next  = (trial_sq <= sum) ? trial : root;
    end

endmodule

// File: rtl/motion_mag_ctrl.sv
// Fixed-latency motion magnitude: out_z = floor(sqrt(x^2+y^2)) over an IDLE/ABS/SUM/ROOT/OUT FSM.
// Optional odometer accumulator enabled by defining MOTION_MAG_ODO_EN.
module motion_mag_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int ODO_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MOVE_W-1:0] in_x,
    input  logic [MOVE_W-1:0] in_y,
    input  logic              in_xovf,
    input  logic              in_yovf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MOVE_W-1:0] out_z,
    output logic              out_sat,
    output logic [ODO_W-1:0]  odo,
    input  logic              odo_clr
);

    mag_state_t state;
    mag_state_t state_next;

    logic [MOVE_W-1:0]    x_r;
    logic [MOVE_W-1:0]    y_r;
    logic                 xovf_r;
    logic                 yovf_r;
    logic [MOVE_W-1:0]    mag_x;
    logic [MOVE_W-1:0]    mag_y;
    logic [SUMSQ_W-1:0]   sum_r;
    logic [MOVE_W-1:0]    root_r;
    logic [MOVE_W-1:0]    root_next;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [MOVE_W-1:0]    z_r;
    logic                 sat_r;
    logic                 handshake;

    mag_isqrt_step u_step (
        .sum       (sum_r),
        .root      (root_r),
        .bit_idx   (bit_idx),
        .root_next (root_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ABS;
                end
            end
            ABS:  state_next = SUM;
            SUM:  state_next = ROOT;
            ROOT: begin
                if (bit_idx == '0) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign handshake = (state == OUT) && out_ready;

    // Overflowed packets still walk the full root sequence so latency never depends on flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r     <= '0;
            y_r     <= '0;
            xovf_r  <= 1'b0;
            yovf_r  <= 1'b0;
            mag_x   <= '0;
            mag_y   <= '0;
            sum_r   <= '0;
            root_r  <= '0;
            bit_idx <= '0;
            z_r     <= '0;
            sat_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r    <= in_x;
                        y_r    <= in_y;
                        xovf_r <= in_xovf;
                        yovf_r <= in_yovf;
                    end
                end
                ABS: begin
                    mag_x <= abs_move(x_r);
                    mag_y <= abs_move(y_r);
                end
                SUM: begin
                    sum_r   <= SUMSQ_W'(mag_x) * SUMSQ_W'(mag_x)
                             + SUMSQ_W'(mag_y) * SUMSQ_W'(mag_y);
                    root_r  <= '0;
                    bit_idx <= BIT_IDX_W'(ROOT_STEPS - 1);
                end
                ROOT: begin
                    root_r <= root_next;
                    if (bit_idx == '0) begin
                        z_r   <= (xovf_r || yovf_r) ? SAT_Z : root_next;
                        sat_r <= xovf_r || yovf_r;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_z   = z_r;
    assign out_sat = sat_r;

`ifdef MOTION_MAG_ODO_EN
    localparam int ODO_SUM_W = ODO_W + 1;

    logic [ODO_W-1:0]     odo_r;
    logic [ODO_SUM_W-1:0] odo_sum;

    assign odo_sum = {1'b0, odo_r} + ODO_SUM_W'(z_r);

    // A clear on the same edge as a handshake discards that packet's distance.
    always_ff @(posedge clk) begin
        if (rst) begin
            odo_r <= '0;
        end else if (odo_clr) begin
            odo_r <= '0;
        end else if (handshake) begin
            odo_r <= odo_sum[ODO_W] ? '1 : odo_sum[ODO_W-1:0];
        end
    end

    assign odo = odo_r;
`else
    logic unused_odo_inputs;

    assign unused_odo_inputs = odo_clr ^ handshake;
    assign odo               = '0;
`endif

endmodule

// File: tb/tb_motion_mag_ctrl.sv
// Scoreboard bench for motion_mag_ctrl: random and directed packets against a plain-arithmetic model.
// Odometer checks are active when MOTION_MAG_ODO_EN is defined.
module tb_motion_mag_ctrl;

    localparam int ODO_W   = 16;
    localparam int LATENCY = 11;

    typedef struct {
        logic [8:0] z;
        logic       sat;
        int         acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [8:0]       in_x;
    logic [8:0]       in_y;
    logic             in_xovf;
    logic             in_yovf;
    logic             out_valid;
    logic             out_ready;
    logic [8:0]       out_z;
    logic             out_sat;
    logic [ODO_W-1:0] odo;
    logic             odo_clr;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   bp_force = 1'b0;
    bit   rand_ready = 1'b0;
    bit   prev_valid = 1'b0;
    logic [8:0] last_z = '0;
    logic       last_sat = 1'b0;
    int   odo_m = 0;

    motion_mag_ctrl #(.ODO_W(ODO_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_xovf   (in_xovf),
        .in_yovf   (in_yovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_sat   (out_sat),
        .odo       (odo),
        .odo_clr   (odo_clr)
    );

    always #5 clk = ~clk;

    // Largest r with r*r <= x*x + y*y, found by counting upward.
    function automatic int ref_mag(input int x, input int y);
        int s;
        int r;
        s = x * x + y * y;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic applyStimulus(input int x, input int y, input bit xo, input bit yo);
        exp_t e;
        int   waited;
        @(negedge clk);
        in_x     = 9'(x);
        in_y     = 9'(y);
        in_xovf  = xo;
        in_yovf  = yo;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (in_ready) begin
            e.sat = xo | yo;
            e.z   = e.sat ? 9'd511 : 9'(ref_mag(x, y));
            e.acc = cyc + 1;
            exp_q.push_back(e);
            @(negedge clk);
        end else begin
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1 within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL idle_timeout: pending %0d, expected 0", exp_q.size());
        end
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bp_force) out_ready = 1'b0;
            else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = 1'b1;
        end
    end

    // Monitor: samples just after each rising edge and replays what that edge should have done.
    initial begin
        exp_t h;
        bit   exp_valid;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                exp_q.delete();
                last_z   = '0;
                last_sat = 1'b0;
                odo_m    = 0;
                checkOutput("rst_out_valid", 32'(out_valid), 0);
                checkOutput("rst_out_z", 32'(out_z), 0);
                checkOutput("rst_out_sat", 32'(out_sat), 0);
                checkOutput("rst_odo", 32'(odo), 0);
                checkOutput("rst_in_ready", 32'(in_ready), 1);
            end else begin
                if (prev_valid && out_ready && exp_q.size() > 0) begin
                    h        = exp_q.pop_front();
                    last_z   = h.z;
                    last_sat = h.sat;
`ifdef MOTION_MAG_ODO_EN
                    odo_m = odo_m + int'(h.z);
                    if (odo_m > (1 << ODO_W) - 1) odo_m = (1 << ODO_W) - 1;
`endif
                end
`ifdef MOTION_MAG_ODO_EN
                if (odo_clr) odo_m = 0;
`endif
                exp_valid = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + LATENCY);
                checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
                checkOutput("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
                if (out_valid && exp_q.size() > 0) begin
                    checkOutput("out_z", 32'(out_z), 32'(exp_q[0].z));
                    checkOutput("out_sat", 32'(out_sat), 32'(exp_q[0].sat));
                end else if (!out_valid) begin
                    checkOutput("held_z", 32'(out_z), 32'(last_z));
                    checkOutput("held_sat", 32'(out_sat), 32'(last_sat));
                end
                checkOutput("odo", 32'(odo), 32'(odo_m));
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int x;
        int y;
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_x     = '0;
        in_y     = '0;
        in_xovf  = 1'b0;
        in_yovf  = 1'b0;
        odo_clr  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        applyStimulus(3, -4, 0, 0);
        applyStimulus(-256, -256, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(255, 0, 0, 0);
        applyStimulus(10, 10, 1, 0);
        applyStimulus(-7, 200, 0, 1);
        waitIdle(100);

        // Reset while the root is being resolved: that packet must vanish.
        applyStimulus(30, 40, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(6, 8, 0, 0);
        waitIdle(100);

        // Backpressure with a second packet waiting on the input.
        bp_force = 1'b1;
        applyStimulus(-100, 75, 0, 0);
        fork
            applyStimulus(12, -5, 0, 0);
            begin
                n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                checkOutput("bp_valid_seen", 32'(out_valid), 1);
                repeat (20) @(negedge clk);
                checkOutput("bp_in_ready", 32'(in_ready), 0);
                bp_force = 1'b0;
            end
        join
        waitIdle(100);

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(0, 511)) - 256;
            y = int'($urandom_range(0, 511)) - 256;
            applyStimulus(x, y, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end
        waitIdle(200);
        rand_ready = 1'b0;

`ifdef MOTION_MAG_ODO_EN
        @(negedge clk);
        odo_clr = 1'b1;
        @(negedge clk);
        odo_clr = 1'b0;
        applyStimulus(3, 4, 0, 0);
        applyStimulus(6, 8, 0, 0);
        applyStimulus(5, 12, 0, 0);
        waitIdle(100);
        @(negedge clk);
        checkOutput("odo_28", 32'(odo), 28);

        odo_clr = 1'b1;
        applyStimulus(3, 4, 0, 0);
        waitIdle(100);
        @(negedge clk);
        odo_clr = 1'b0;
        checkOutput("odo_clr_wins", 32'(odo), 0);

        for (int i = 0; i < 130; i++) applyStimulus(10, 10, 1, 0);
        waitIdle(100);
        @(negedge clk);
        checkOutput("odo_saturate", 32'(odo), 32'hFFFF);
`else
        @(negedge clk);
        odo_clr = 1'b1;
        applyStimulus(3, 4, 0, 0);
        waitIdle(100);
        odo_clr = 1'b0;
        @(negedge clk);
        checkOutput("odo_disabled", 32'(odo), 0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
